// File: rtl/iir_sos_cascade.sv
// iir_sos_cascade
//   Time-multiplexed cascade of NUM_SOS direct-form-II biquad sections that
//   share one multiplier. Each section takes six clocks. A runtime-writable
//   coefficient bank, per-section w1/w2 state, saturation and a sticky
//   overflow flag are included.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready  input sample handshake (in_ready high only in IDLE)
//   in_data            input sample, signed DATA_W
//   out_valid/out_ready output handshake; out_data held while stalled
//   out_data           filtered sample, signed DATA_W
//   coef_we/coef_addr/coef_wdata  coefficient write (addr = section*5 + k,
//                      k: 0=b0 1=b1 2=b2 3=a1 4=a2)
//   coef_err           one-cycle pulse when a write is dropped
//   clear_state        zero all w1/w2 state and sat_flag
//   sat_flag           sticky saturation indicator
//   busy               high whenever the FSM is not IDLE
//
// Build option
//   IIR_SOS_ROUND_EN   when defined, every product is rounded half up
//                      before the right shift; otherwise truncated.
module iir_sos_cascade #(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 24,
  parameter int COEF_FRAC = 22,
  parameter int NUM_SOS   = 4,
  parameter int GUARD_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  input  logic                          coef_we,
  input  logic [$clog2(NUM_SOS*5)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]             coef_wdata,
  output logic                          coef_err,
  input  logic                          clear_state,
  output logic                          sat_flag,
  output logic                          busy
);

  localparam int ACC_W  = DATA_W + GUARD_W;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int NCOEF  = NUM_SOS * 5;
  localparam int CA_W   = $clog2(NCOEF);
  localparam int SEC_W  = (NUM_SOS > 1) ? $clog2(NUM_SOS) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(GUARD_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(GUARD_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [COEF_W-1:0] COEF_ONE = {{(COEF_W-1){1'b0}}, 1'b1} << COEF_FRAC;
`ifdef IIR_SOS_ROUND_EN
  localparam logic signed [PROD_W-1:0] ROUND_K = {{(PROD_W-1){1'b0}}, 1'b1} << (COEF_FRAC-1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Clamp an accumulator value to the sample range; MSB of the result flags a clip.
  function automatic logic [DATA_W:0] sat_fn(input logic signed [ACC_W-1:0] a);
    logic [DATA_W:0] r;
    if (a > SAT_MAX) begin
      r = {1'b1, SAT_MAX[DATA_W-1:0]};
    end else if (a < SAT_MIN) begin
      r = {1'b1, SAT_MIN[DATA_W-1:0]};
    end else begin
      r = {1'b0, a[DATA_W-1:0]};
    end
    return r;
  endfunction

  state_t                     state_r;
  state_t                     state_nx_s;
  logic [SEC_W-1:0]           sec_r;
  logic [2:0]                 step_r;
  logic signed [DATA_W-1:0]   x_cur_r;
  logic signed [DATA_W-1:0]   w0_tmp_r;
  logic signed [ACC_W-1:0]    acc_r;
  logic signed [COEF_W-1:0]   coef_r     [NCOEF];
  logic signed [COEF_W-1:0]   act_coef_r [NCOEF];
  logic signed [DATA_W-1:0]   w1_r       [NUM_SOS];
  logic signed [DATA_W-1:0]   w2_r       [NUM_SOS];
  logic                       clear_pend_r;
  logic                       out_valid_r;
  logic [DATA_W-1:0]          out_data_r;
  logic                       coef_err_r;
  logic                       sat_flag_r;

  logic [2:0]                 k_s;
  logic [CA_W-1:0]            coef_idx_s;
  logic signed [COEF_W-1:0]   coef_op_s;
  logic signed [DATA_W-1:0]   data_op_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [PROD_W-1:0]   prod_rnd_s;
  logic signed [ACC_W-1:0]    prod_acc_s;
  logic [DATA_W:0]            sat_acc_s;
  logic signed [DATA_W-1:0]   sat_val_s;
  logic                       sat_hit_s;
  logic                       last_sec_s;
  logic                       coef_ok_s;
  logic                       do_clear_s;

  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign coef_err  = coef_err_r;
  assign sat_flag  = sat_flag_r;

  // Shared multiplier: pick coefficient and data operand for the current step.
  always_comb begin
    k_s       = 3'd0;
    data_op_s = '0;
    sat_acc_s = sat_fn(acc_r);
    sat_val_s = signed'(sat_acc_s[DATA_W-1:0]);
    sat_hit_s = sat_acc_s[DATA_W];
    case (step_r)
      3'd0: begin k_s = 3'd3; data_op_s = w1_r[sec_r]; end
      3'd1: begin k_s = 3'd4; data_op_s = w2_r[sec_r]; end
      3'd2: begin k_s = 3'd0; data_op_s = sat_val_s;   end  // b0 * sat(acc) = b0 * w0
      3'd3: begin k_s = 3'd1; data_op_s = w1_r[sec_r]; end
      3'd4: begin k_s = 3'd2; data_op_s = w2_r[sec_r]; end
      default: begin k_s = 3'd0; data_op_s = '0;        end
    endcase
    coef_idx_s = CA_W'(sec_r) * CA_W'(3'd5) + CA_W'(k_s);
    coef_op_s  = act_coef_r[coef_idx_s];
    prod_s     = PROD_W'(coef_op_s) * PROD_W'(data_op_s);
`ifdef IIR_SOS_ROUND_EN
    prod_rnd_s = prod_s + ROUND_K;
`else
    prod_rnd_s = prod_s;
`endif
    prod_acc_s = ACC_W'(prod_rnd_s >>> COEF_FRAC);
  end

  // Control qualifiers shared by the FSM and datapath.
  always_comb begin
    last_sec_s = (sec_r == SEC_W'(NUM_SOS-1));
    coef_ok_s  = (state_r == ST_IDLE) && (int'(coef_addr) < NCOEF);
    do_clear_s = (state_r == ST_IDLE) && (clear_state || clear_pend_r);
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nx_s = ST_MAC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        if ((step_r == 3'd5) && last_sec_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_MAC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Coefficient bank: writes land only in IDLE with an in-range address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) begin
        coef_r[i] <= ((i % 5) == 0) ? COEF_ONE : '0;
      end
      coef_err_r <= 1'b0;
    end else begin
      coef_err_r <= 1'b0;
      if (coef_we) begin
        if (coef_ok_s) begin
          coef_r[coef_addr] <= coef_wdata;
        end else begin
          coef_err_r <= 1'b1;
        end
      end
    end
  end

  // Datapath: sample capture, six-step MAC sequence, state update and output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) begin
        act_coef_r[i] <= ((i % 5) == 0) ? COEF_ONE : '0;
      end
      for (int s = 0; s < NUM_SOS; s++) begin
        w1_r[s] <= '0;
        w2_r[s] <= '0;
      end
      sec_r        <= '0;
      step_r       <= 3'd0;
      x_cur_r      <= '0;
      w0_tmp_r     <= '0;
      acc_r        <= '0;
      clear_pend_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      sat_flag_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (do_clear_s) begin
            for (int s = 0; s < NUM_SOS; s++) begin
              w1_r[s] <= '0;
              w2_r[s] <= '0;
            end
            sat_flag_r   <= 1'b0;
            clear_pend_r <= 1'b0;
          end
          if (in_valid) begin
            x_cur_r <= in_data;
            sec_r   <= '0;
            step_r  <= 3'd0;
            // Snapshot the bank before any same-edge write lands, so such a
            // write only affects the following sample.
            for (int i = 0; i < NCOEF; i++) begin
              act_coef_r[i] <= coef_r[i];
            end
          end
        end
        ST_MAC: begin
          if (clear_state) begin
            clear_pend_r <= 1'b1;
          end
          case (step_r)
            3'd0: begin
              acc_r  <= ACC_W'(x_cur_r) - prod_acc_s;
              step_r <= 3'd1;
            end
            3'd1: begin
              acc_r  <= acc_r - prod_acc_s;
              step_r <= 3'd2;
            end
            3'd2: begin
              w0_tmp_r <= sat_val_s;
              if (sat_hit_s) begin
                sat_flag_r <= 1'b1;
              end
              acc_r  <= prod_acc_s;
              step_r <= 3'd3;
            end
            3'd3: begin
              acc_r  <= acc_r + prod_acc_s;
              step_r <= 3'd4;
            end
            3'd4: begin
              acc_r  <= acc_r + prod_acc_s;
              step_r <= 3'd5;
            end
            3'd5: begin
              x_cur_r     <= sat_val_s;
              if (sat_hit_s) begin
                sat_flag_r <= 1'b1;
              end
              w2_r[sec_r] <= w1_r[sec_r];
              w1_r[sec_r] <= w0_tmp_r;
              step_r      <= 3'd0;
              if (last_sec_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= sat_val_s;
              end else begin
                sec_r <= sec_r + SEC_W'(1'b1);
              end
            end
            default: step_r <= 3'd0;
          endcase
        end
        ST_DONE: begin
          if (clear_state) begin
            clear_pend_r <= 1'b1;
          end
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/iir_sos_cascade.md
Name: iir_sos_cascade

Overview:
- Parametrised successor to the single-section biquad: a time-multiplexed cascade of NUM_SOS direct-form-II biquad sections sharing one multiplier.
- Includes a runtime-writable coefficient bank, a valid/ready sample handshake with output backpressure, per-section state storage, saturation and a sticky overflow flag.
- Sits between the sample source and downstream DSP in the IIR filter path.

Parameters:
- DATA_W, 24, sample/state width, signed two's complement.
- COEF_W, 24, coefficient width, signed.
- COEF_FRAC, 22, coefficient fractional bits (1.0 = 2^COEF_FRAC).
- NUM_SOS, 4, number of cascaded sections, 1..16.
- GUARD_W, 4, accumulator guard bits (accumulator width DATA_W+GUARD_W).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts sample; high only in IDLE.
- in_data  in  DATA_W  input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DATA_W  filtered sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(NUM_SOS*5)  coefficient address = section*5 + k, where k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- coef_wdata  in  COEF_W  coefficient value.
- coef_err  out  1  one-cycle pulse: write dropped (busy or address out of range).
- clear_state  in  1  request to zero all w1/w2 state and sat_flag.
- sat_flag  out  1  sticky: any saturation occurred.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE; all w1/w2 = 0; coefficients b0 = 2^COEF_FRAC, all others 0 (passthrough); out_valid=0; out_data=0; coef_err=0; sat_flag=0; pending clear=0.
- FSM states: IDLE, MAC, DONE.
  - IDLE: in_ready=1. When in_valid=1: latch in_data into x_cur, set sec=0, step=0, go to MAC.
- MAC runs 6 steps per section, one clock each. Products are full-width DATA_W+COEF_W, arithmetically shifted right by COEF_FRAC (truncation), then sign-extended to the accumulator width.
  - step0: acc = x_cur - (a1*w1)>>F
  - step1: acc -= (a2*w2)>>F
  - step2: w0_tmp = sat(acc); acc = (b0*w0_tmp)>>F
  - step3: acc += (b1*w1)>>F
  - step4: acc += (b2*w2)>>F
  - step5: x_cur = sat(acc); w2 = w1; w1 = w0_tmp. Then sec++, step=0. After the last section, go to DONE.
- sat(): clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp in step2 or step5 sets sat_flag.
- DONE: out_valid=1, out_data=x_cur, both held stable while out_ready=0. When out_ready=1: handshake completes, out_valid=0 next cycle, go to IDLE.
- Timing:
  - Latency: out_valid rises exactly 6*NUM_SOS clocks after the accepting edge.
  - Minimum sample period: 6*NUM_SOS+2 clocks.
- Coefficient writes:
  - Applied at the clock edge only in IDLE with a valid address.
  - Otherwise dropped, and coef_err pulses for 1 cycle.
  - A write and an input accept on the same IDLE edge: the write lands, but the new value is used from the next sample.
- clear_state:
  - In IDLE: zeroes all w1/w2 and sat_flag at that edge; an input accepted on the same edge starts with zeroed state.
  - When busy: latched as pending and applied on the first IDLE cycle, before any accept.
- Reset mid-operation: aborts immediately to reset values; the in-flight sample is lost.

Optional Feature:
- Macro: IIR_SOS_ROUND_EN.
- Defined: every product adds 2^(COEF_FRAC-1) before the right shift (round half up).
- Undefined: plain arithmetic-shift truncation.
- All other behaviour is identical.

Test Plan:
- Passthrough: reset, in_data=1000 → out_data=1000, out_valid rising 24 clocks after accept (NUM_SOS=4).
- Gain: write section0 b0=2097152 (0.5), in_data=1000 → out_data=500.
- Feedback: section0 a1=-2097152 (-0.5); impulse 4096 followed by zeros → outputs 4096, 2048, 1024, 512, 256.
- Saturation: all b0=6291456 (1.5), in_data=8000000 → out_data=8388607, sat_flag=1. Then clear_state → sat_flag=0.
- Backpressure and busy write:
  - Hold out_ready=0 for 10 cycles → out_data stable, in_ready=0.
  - A coef_we issued while busy → coef_err pulse; a later sample shows the old coefficient in use.
- Reset mid-MAC: assert rst at step3 of section1 → out_valid=0 and in_ready=1 after release. The next input 1000 → output 1000, confirming state and coefficients were reset.
